// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM encoding, held accelerator request, defaults.
package sram_arb_pkg;

    localparam int REQ_AW           = 14;
    localparam int STARVE_LIMIT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              write;
        logic [REQ_AW-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } acc_req_t;

endpackage

// File: rtl/sram_arb_wait_cnt.sv
// Saturating count of cycles the held accelerator request has been blocked, plus starvation flag.
// Count updates one cycle after inc/clr; starve tracks the registered count (no backpressure).
module sram_arb_wait_cnt #(
    parameter int CW           = 16,
    parameter int STARVE_LIMIT = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          starve
);

    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // starve is derived from the next count so it always agrees with cnt in the same cycle
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt    <= '0;
            starve <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            starve <= (cnt_nxt >= CW'(STARVE_LIMIT));
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port: the AHB bridge always wins, the accelerator takes idle cycles only.
// Capture N, issue >= N+1, read data N+2; bridge never stalled, accelerator held off via ACC_READY.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW           = REQ_AW,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CW           = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          AHB_CS,
    input  logic [3:0]    AHB_WEN,
    input  logic [AW-1:0] AHB_ADDR,
    input  logic [31:0]   AHB_WDATA,
    output logic [31:0]   AHB_RDATA,
    input  logic          ACC_VALID,
    output logic          ACC_READY,
    input  logic          ACC_WRITE,
    input  logic [AW-1:0] ACC_ADDR,
    input  logic [3:0]    ACC_BE,
    input  logic [31:0]   ACC_WDATA,
    output logic          ACC_RVALID,
    output logic [31:0]   ACC_RDATA,
    output logic          ACC_STARVE,
    output logic [CW-1:0] ACC_WAIT_CNT,
    output logic          SRAMCS,
    output logic [3:0]    SRAMWEN,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    input  logic [31:0]   SRAMRDATA
);

    arb_state_e state;
    acc_req_t   hold;
    logic       pend;
    logic       issue;
    logic       capture;

    assign pend    = (state == ST_PEND);
    assign issue   = pend & ~AHB_CS;
    assign capture = ACC_VALID & ACC_READY;

    assign ACC_READY  = (state == ST_IDLE);
    assign ACC_RVALID = (state == ST_RESP);

    // An accelerator read in cycle N excludes a bridge read in N, so the return path can be shared.
    assign AHB_RDATA = SRAMRDATA;
    assign ACC_RDATA = SRAMRDATA;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (capture) state <= ST_PEND;
                ST_PEND: if (!AHB_CS) state <= hold.write ? ST_IDLE : ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hold <= '0;
        end else if (capture) begin
            hold.write <= ACC_WRITE;
            hold.addr  <= ACC_ADDR;
            hold.be    <= ACC_BE;
            hold.wdata <= ACC_WDATA;
        end
    end

    always_comb begin
        SRAMCS    = AHB_CS;
        SRAMWEN   = AHB_WEN;
        SRAMADDR  = AHB_ADDR;
        SRAMWDATA = AHB_WDATA;
        if (issue) begin
            SRAMCS    = 1'b1;
            SRAMWEN   = hold.write ? hold.be : 4'h0;
            SRAMADDR  = hold.addr;
            SRAMWDATA = hold.wdata;
        end
        // Keep the macro quiet while reset is held, whatever the bridge pins are doing.
        if (HRESET) begin
            SRAMCS  = 1'b0;
            SRAMWEN = 4'h0;
        end
    end

    sram_arb_wait_cnt #(
        .CW           (CW),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wait_cnt (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .inc    (pend & AHB_CS),
        .clr    (~pend | issue),
        .cnt    (ACC_WAIT_CNT),
        .starve (ACC_STARVE)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural byte-lane SRAM.
module tb_sram_port_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        AHB_CS;
    logic [3:0]  AHB_WEN;
    logic [13:0] AHB_ADDR;
    logic [31:0] AHB_WDATA;
    logic [31:0] AHB_RDATA;
    logic        ACC_VALID;
    logic        ACC_READY;
    logic        ACC_WRITE;
    logic [13:0] ACC_ADDR;
    logic [3:0]  ACC_BE;
    logic [31:0] ACC_WDATA;
    logic        ACC_RVALID;
    logic [31:0] ACC_RDATA;
    logic        ACC_STARVE;
    logic [15:0] ACC_WAIT_CNT;
    logic        SRAMCS;
    logic [3:0]  SRAMWEN;
    logic [13:0] SRAMADDR;
    logic [31:0] SRAMWDATA;
    logic [31:0] SRAMRDATA;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:255];
    logic [31:0] sram_q;

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (SRAMCS) begin
            for (int b = 0; b < 4; b++)
                if (SRAMWEN[b]) mem[SRAMADDR[7:0]][b*8 +: 8] <= SRAMWDATA[b*8 +: 8];
            if (SRAMWEN == 4'h0) sram_q <= mem[SRAMADDR[7:0]];
        end
    end
    assign SRAMRDATA = sram_q;

    sram_port_arbiter dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .AHB_CS       (AHB_CS),
        .AHB_WEN      (AHB_WEN),
        .AHB_ADDR     (AHB_ADDR),
        .AHB_WDATA    (AHB_WDATA),
        .AHB_RDATA    (AHB_RDATA),
        .ACC_VALID    (ACC_VALID),
        .ACC_READY    (ACC_READY),
        .ACC_WRITE    (ACC_WRITE),
        .ACC_ADDR     (ACC_ADDR),
        .ACC_BE       (ACC_BE),
        .ACC_WDATA    (ACC_WDATA),
        .ACC_RVALID   (ACC_RVALID),
        .ACC_RDATA    (ACC_RDATA),
        .ACC_STARVE   (ACC_STARVE),
        .ACC_WAIT_CNT (ACC_WAIT_CNT),
        .SRAMCS       (SRAMCS),
        .SRAMWEN      (SRAMWEN),
        .SRAMADDR     (SRAMADDR),
        .SRAMWDATA    (SRAMWDATA),
        .SRAMRDATA    (SRAMRDATA)
    );

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic acc_drive(input logic wr, input logic [13:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        ACC_VALID = 1'b1;
        ACC_WRITE = wr;
        ACC_ADDR  = a;
        ACC_BE    = be;
        ACC_WDATA = d;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        AHB_CS = 1'b1;
        AHB_WEN = 4'hF;
        repeat (3) next_cycle();
        @(negedge HCLK);
        checks++;
        if (SRAMCS !== 1'b0 || SRAMWEN !== 4'h0) begin
            fails++;
            $display("FAIL reset_sram_quiet: cs=%b wen=%h, want cs=0 wen=0", SRAMCS, SRAMWEN);
        end
        next_cycle();
        HRESET = 1'b0;
        AHB_CS = 1'b0;
        AHB_WEN = 4'h0;
        @(negedge HCLK);
        checks++;
        if (ACC_READY !== 1'b1 || ACC_RVALID !== 1'b0 || ACC_STARVE !== 1'b0 ||
            ACC_WAIT_CNT !== 16'd0 || SRAMCS !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b rv=%b st=%b cnt=%0d cs=%b, want 1 0 0 0 0",
                     ACC_READY, ACC_RVALID, ACC_STARVE, ACC_WAIT_CNT, SRAMCS);
        end
    endtask

    task automatic test_idle_write();
        next_cycle();
        acc_drive(1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
        @(negedge HCLK);
        checks++;
        if (ACC_READY !== 1'b1 || SRAMCS !== 1'b0) begin
            fails++;
            $display("FAIL wr_capture: rdy=%b cs=%b, want rdy=1 cs=0", ACC_READY, SRAMCS);
        end
        next_cycle();
        ACC_VALID = 1'b0;
        @(negedge HCLK);
        checks++;
        if (SRAMCS !== 1'b1 || SRAMWEN !== 4'hF || SRAMADDR !== 14'h0010 ||
            SRAMWDATA !== 32'hDEADBEEF || ACC_READY !== 1'b0) begin
            fails++;
            $display("FAIL wr_issue: cs=%b wen=%h addr=%h wd=%h rdy=%b, want 1 f 0010 deadbeef 0",
                     SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA, ACC_READY);
        end
        next_cycle();
        @(negedge HCLK);
        checks++;
        if (ACC_READY !== 1'b1 || SRAMCS !== 1'b0 || ACC_RVALID !== 1'b0) begin
            fails++;
            $display("FAIL wr_done: rdy=%b cs=%b rv=%b, want 1 0 0", ACC_READY, SRAMCS, ACC_RVALID);
        end
    endtask

    task automatic test_read_back();
        next_cycle();
        acc_drive(1'b0, 14'h0010, 4'h0, 32'h0);
        next_cycle();
        ACC_VALID = 1'b0;
        @(negedge HCLK);
        checks++;
        if (SRAMCS !== 1'b1 || SRAMWEN !== 4'h0 || SRAMADDR !== 14'h0010) begin
            fails++;
            $display("FAIL rd_issue: cs=%b wen=%h addr=%h, want 1 0 0010", SRAMCS, SRAMWEN, SRAMADDR);
        end
        next_cycle();
        @(negedge HCLK);
        checks++;
        if (ACC_RVALID !== 1'b1 || ACC_RDATA !== 32'hDEADBEEF || ACC_READY !== 1'b0) begin
            fails++;
            $display("FAIL rd_resp: rv=%b rd=%h rdy=%b, want 1 deadbeef 0",
                     ACC_RVALID, ACC_RDATA, ACC_READY);
        end
        next_cycle();
        @(negedge HCLK);
        checks++;
        if (ACC_RVALID !== 1'b0 || ACC_READY !== 1'b1) begin
            fails++;
            $display("FAIL rd_after: rv=%b rdy=%b, want 0 1", ACC_RVALID, ACC_READY);
        end
    endtask

    task automatic test_contention();
        next_cycle();
        AHB_CS    = 1'b1;
        AHB_WEN   = 4'h0;
        AHB_ADDR  = 14'h0100;
        AHB_WDATA = 32'h0;
        acc_drive(1'b1, 14'h0030, 4'hF, 32'hCAFEF00D);
        next_cycle();
        ACC_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            checks++;
            if (SRAMADDR !== 14'h0100 || ACC_WAIT_CNT !== 16'(i) || ACC_READY !== 1'b0) begin
                fails++;
                $display("FAIL contend_%0d: addr=%h cnt=%0d rdy=%b, want 0100 %0d 0",
                         i, SRAMADDR, ACC_WAIT_CNT, ACC_READY, i);
            end
            next_cycle();
        end
        AHB_CS = 1'b0;
        @(negedge HCLK);
        checks++;
        if (ACC_WAIT_CNT !== 16'd10 || SRAMCS !== 1'b1 || SRAMADDR !== 14'h0030 ||
            SRAMWDATA !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL contend_issue: cnt=%0d cs=%b addr=%h wd=%h, want 10 1 0030 cafef00d",
                     ACC_WAIT_CNT, SRAMCS, SRAMADDR, SRAMWDATA);
        end
        next_cycle();
        @(negedge HCLK);
        checks++;
        if (ACC_WAIT_CNT !== 16'd0 || ACC_READY !== 1'b1) begin
            fails++;
            $display("FAIL contend_clear: cnt=%0d rdy=%b, want 0 1", ACC_WAIT_CNT, ACC_READY);
        end
    endtask

    task automatic test_starvation();
        next_cycle();
        AHB_CS   = 1'b1;
        AHB_ADDR = 14'h0101;
        acc_drive(1'b1, 14'h0040, 4'hF, 32'h5A5A5A5A);
        next_cycle();
        ACC_VALID = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge HCLK);
            checks++;
            if (ACC_STARVE !== (i >= 64) || ACC_WAIT_CNT !== 16'(i)) begin
                fails++;
                $display("FAIL starve_%0d: st=%b cnt=%0d, want %0d %0d",
                         i, ACC_STARVE, ACC_WAIT_CNT, (i >= 64), i);
            end
            next_cycle();
        end
        AHB_CS = 1'b0;
        @(negedge HCLK);
        checks++;
        if (ACC_STARVE !== 1'b1 || SRAMCS !== 1'b1 || SRAMADDR !== 14'h0040) begin
            fails++;
            $display("FAIL starve_issue: st=%b cs=%b addr=%h, want 1 1 0040",
                     ACC_STARVE, SRAMCS, SRAMADDR);
        end
        next_cycle();
        @(negedge HCLK);
        checks++;
        if (ACC_STARVE !== 1'b0 || ACC_WAIT_CNT !== 16'd0) begin
            fails++;
            $display("FAIL starve_drop: st=%b cnt=%0d, want 0 0", ACC_STARVE, ACC_WAIT_CNT);
        end
    endtask

    task automatic test_byte_write();
        next_cycle();
        AHB_CS    = 1'b1;
        AHB_WEN   = 4'hF;
        AHB_ADDR  = 14'h0020;
        AHB_WDATA = 32'h11223344;
        @(negedge HCLK);
        checks++;
        if (SRAMCS !== 1'b1 || SRAMWEN !== 4'hF || SRAMADDR !== 14'h0020 ||
            SRAMWDATA !== 32'h11223344) begin
            fails++;
            $display("FAIL ahb_passthru: cs=%b wen=%h addr=%h wd=%h, want 1 f 0020 11223344",
                     SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA);
        end
        next_cycle();
        AHB_CS  = 1'b0;
        AHB_WEN = 4'h0;
        acc_drive(1'b1, 14'h0020, 4'b0100, 32'h00AB0000);
        next_cycle();
        ACC_VALID = 1'b0;
        @(negedge HCLK);
        checks++;
        if (SRAMWEN !== 4'b0100 || SRAMADDR !== 14'h0020) begin
            fails++;
            $display("FAIL bw_issue: wen=%h addr=%h, want 4 0020", SRAMWEN, SRAMADDR);
        end
        next_cycle();
        AHB_CS = 1'b1;
        next_cycle();
        AHB_CS = 1'b0;
        @(negedge HCLK);
        checks++;
        if (AHB_RDATA !== 32'h11AB3344) begin
            fails++;
            $display("FAIL bw_readback: rdata=%h, want 11ab3344", AHB_RDATA);
        end
    endtask

    task automatic test_reset_mid_pend();
        next_cycle();
        AHB_CS   = 1'b1;
        AHB_WEN  = 4'h0;
        AHB_ADDR = 14'h0102;
        acc_drive(1'b1, 14'h0050, 4'hF, 32'h0BADF00D);
        next_cycle();
        ACC_VALID = 1'b0;
        repeat (3) next_cycle();
        HRESET = 1'b1;
        @(negedge HCLK);
        checks++;
        if (SRAMCS !== 1'b0 || ACC_WAIT_CNT !== 16'd0) begin
            fails++;
            $display("FAIL rst_pend_hold: cs=%b cnt=%0d, want 0 0", SRAMCS, ACC_WAIT_CNT);
        end
        next_cycle();
        HRESET = 1'b0;
        AHB_CS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            checks++;
            if (SRAMCS !== 1'b0 || ACC_READY !== 1'b1 || ACC_WAIT_CNT !== 16'd0 ||
                ACC_STARVE !== 1'b0) begin
                fails++;
                $display("FAIL rst_pend_%0d: cs=%b rdy=%b cnt=%0d st=%b, want 0 1 0 0",
                         i, SRAMCS, ACC_READY, ACC_WAIT_CNT, ACC_STARVE);
            end
            next_cycle();
        end
    endtask

    initial begin
        HRESET    = 1'b1;
        AHB_CS    = 1'b0;
        AHB_WEN   = 4'h0;
        AHB_ADDR  = 14'h0;
        AHB_WDATA = 32'h0;
        ACC_VALID = 1'b0;
        ACC_WRITE = 1'b0;
        ACC_ADDR  = 14'h0;
        ACC_BE    = 4'h0;
        ACC_WDATA = 32'h0;
        test_reset();
        test_idle_write();
        test_read_back();
        test_contention();
        test_starvation();
        test_byte_write();
        test_reset_mid_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port synchronous on-chip SRAM between two masters: the AHB-lite SRAM bridge (fixed priority, never stalled) and the PID accelerator's local memory port (valid/ready request, read response one cycle after issue).
- Sits between the bridge's SRAM-side pins and the SRAM macro.
- The accelerator uses only idle SRAM cycles.
- A starvation counter flags when the accelerator has waited too long.

Parameters:
- AW, 14, SRAM word-address width.
- STARVE_LIMIT, 64, wait cycles in PEND at which ACC_STARVE asserts.
- CW, 16, width of the wait counter (saturating).

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  asynchronous, active-high reset.
- AHB_CS  in  1  bridge chip select.
- AHB_WEN  in  4  bridge byte write enables.
- AHB_ADDR  in  AW  bridge word address.
- AHB_WDATA  in  32  bridge write data.
- AHB_RDATA  out  32  read data to bridge.
- ACC_VALID  in  1  accelerator request valid.
- ACC_READY  out  1  arbiter can capture a request.
- ACC_WRITE  in  1  1 = write, 0 = read.
- ACC_ADDR  in  AW  accelerator word address.
- ACC_BE  in  4  accelerator byte enables (writes only).
- ACC_WDATA  in  32  accelerator write data.
- ACC_RVALID  out  1  read data valid, one-cycle pulse.
- ACC_RDATA  out  32  read data.
- ACC_STARVE  out  1  waiting at or beyond STARVE_LIMIT.
- ACC_WAIT_CNT  out  CW  current wait count.
- SRAMCS  out  1  SRAM chip select.
- SRAMWEN  out  4  SRAM byte write enables.
- SRAMADDR  out  AW  SRAM address.
- SRAMWDATA  out  32  SRAM write data.
- SRAMRDATA  in  32  SRAM read data (valid the cycle after a read CS).

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = IDLE, holding register cleared, wait count = 0.
  - ACC_READY = 1 once reset is released.
  - ACC_RVALID = 0, ACC_STARVE = 0.
  - SRAMCS = 0, SRAMWEN = 0.
- Reset asserted mid-operation discards the captured request without issuing it.
- States:
  - IDLE: ACC_READY = 1. ACC_VALID & ACC_READY captures ACC_WRITE/ADDR/BE/WDATA into the holding register, then go to PEND. The request is never issued in its capture cycle.
  - PEND: ACC_READY = 0.
    - AHB_CS = 1: the bridge owns the SRAM and the wait count increments, saturating at 2^CW-1.
    - AHB_CS = 0: issue the held request that cycle. Drive SRAMCS = 1, SRAMADDR = held address, SRAMWEN = held BE if write else 0, SRAMWDATA = held data. Next state is IDLE for a write, RESP for a read.
  - RESP: ACC_RVALID = 1, ACC_RDATA = SRAMRDATA, then return to IDLE. ACC_READY = 0 in RESP. The bridge may use the SRAM during RESP.
- Mux:
  - When the accelerator is not issuing, the SRAM pins equal the bridge inputs combinationally (CS/WEN/ADDR/WDATA).
  - Issue condition is (state == PEND) & ~AHB_CS. There is never a simultaneous grant.
- Read data:
  - AHB_RDATA = SRAMRDATA, unconditional pass-through.
  - This is safe because an accelerator read in cycle N implies no bridge address-phase read in N, so there is no bridge read data phase in N+1.
  - ACC_RDATA = SRAMRDATA is qualified only by ACC_RVALID.
- Latency:
  - Capture N, issue at N+1 at the earliest, RVALID at N+2.
  - Best-case throughput is 1 write per 2 cycles and 1 read per 3 cycles.
- Wait count and starvation:
  - ACC_WAIT_CNT clears on issue; it is only non-zero in PEND.
  - ACC_STARVE = (ACC_WAIT_CNT >= STARVE_LIMIT), registered. It drops the cycle after issue.
- Continuous bridge traffic starves the accelerator indefinitely. This is by design: the bridge has HREADYOUT tied high. The starvation output exists for software/interrupt visibility only.
- Coherence:
  - The bridge merges its buffered write data into reads that hit the buffered address.
  - Accelerator writes to a word the bridge has buffered can therefore be masked on a subsequent AHB read.
  - Software partitions the address space; the arbiter does no address compare.
- ACC_VALID dropping while in PEND/RESP has no effect; the request was already captured.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state encoding enum (IDLE=2'd0, PEND=2'd1, RESP=2'd2);
  - a request struct {write, addr, be, wdata};
  - the default STARVE_LIMIT constant.
- One natural sub-module: sram_arb_wait_cnt, the saturating counter plus threshold compare.
- The FSM, holding register and mux stay in the top module.

Test Plan:
- Idle bus:
  - Accelerator write ADDR=0x0010, BE=4'hF, WDATA=0xDEADBEEF captured at cycle 1.
  - SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=0x0010 at cycle 2; ACC_READY returns to 1 at cycle 3.
- Read-back:
  - Accelerator read ADDR=0x0010 captured at cycle 5, issued at cycle 6 with SRAMWEN=0.
  - ACC_RVALID=1 with ACC_RDATA=0xDEADBEEF at cycle 7.
- Contention:
  - AHB_CS held high for 10 cycles while a request sits in PEND.
  - No accelerator issue occurs; ACC_WAIT_CNT reaches 10. Issue happens the first cycle AHB_CS=0, and the count returns to 0 the next cycle.
- Starvation:
  - STARVE_LIMIT=64, AHB_CS high for 70 cycles.
  - ACC_STARVE rises after wait count 64 and falls the cycle after issue.
- Byte write:
  - Accelerator BE=4'b0100, WDATA=0x00AB0000 to address 0x0020 containing 0x11223344.
  - A later AHB read returns 0x11AB3344.
- Reset mid-PEND:
  - Assert HRESET with a request in PEND and AHB_CS high.
  - SRAMCS never asserts for that request; ACC_READY=1 after release; counters = 0.
